gate_tester: RTL and testbench

Automatic truth-table checker for two-input logic gates. Drives A/B stimulus into the device under test (the gate modules of this codebase or an external gate wired to FPGA pins), waits for the output to settle, samples C, and compares it against the expected function selected at start. It reports pass/fail per input vector and sits on the lab board between the switches/LEDs and the gate being exercised.

---
 rtl/gate_tester.sv | 131 +++++++++++++
 tb/tb_gate_tester.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_tester.sv
// Truth-table checker for a two-input gate: drives all four {A,B} vectors,
// lets the gate output settle, samples it through a synchronizer and flags mismatches.
module gate_tester #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] sel,
    input  logic       c_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic       err_sel,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state, next_state;
    logic [1:0] vec;
    logic [7:0] settle_cnt;
    logic       c_meta, c_s;
    logic [2:0] sel_q;
    logic       sel_legal;
    logic       expected;
    logic       mismatch;
    logic [3:0] fail_next;

    // Stimulus comes straight from the vector counter, so it holds 11 after a run.
    assign a_out     = vec[1];
    assign b_out     = vec[0];
    assign busy      = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_CHECK);
    assign done      = (state == S_DONE);
    assign state_dbg = state;
    assign sel_legal = (sel <= 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_meta <= 1'b0;
            c_s    <= 1'b0;
        end else begin
            c_meta <= c_in;
            c_s    <= c_meta;
        end
    end

    always_comb begin
        expected = 1'b0;
        case (sel_q)
            3'd0:    expected = vec[1] & vec[0];
            3'd1:    expected = vec[1] | vec[0];
            3'd2:    expected = ~(vec[1] & vec[0]);
            3'd3:    expected = ~(vec[1] | vec[0]);
            3'd4:    expected = vec[1] ^ vec[0];
            3'd5:    expected = ~(vec[1] ^ vec[0]);
            default: expected = 1'b0;
        endcase
        mismatch       = (c_s != expected);
        fail_next      = fail_vec;
        fail_next[vec] = mismatch;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) next_state = sel_legal ? S_DRIVE : S_DONE;
            end
            S_DRIVE:  next_state = S_SETTLE;
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) next_state = S_CHECK;
            end
            S_CHECK:  next_state = (vec == 2'd3) ? S_DONE : S_DRIVE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= 2'd0;
            settle_cnt <= 8'd0;
            sel_q      <= 3'd0;
            fail_vec   <= 4'd0;
            pass       <= 1'b0;
            err_sel    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        fail_vec <= 4'd0;
                        pass     <= 1'b0;
                        if (sel_legal) begin
                            sel_q   <= sel;
                            err_sel <= 1'b0;
                            vec     <= 2'd0;
                        end else begin
                            err_sel <= 1'b1;
                        end
                    end
                end
                S_DRIVE:  settle_cnt <= 8'd0;
                S_SETTLE: settle_cnt <= settle_cnt + 8'd1;
                S_CHECK: begin
                    fail_vec <= fail_next;
                    if (vec == 2'd3) pass <= ~err_sel & (fail_next == 4'd0);
                    else             vec  <= vec + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tester.sv
// Self-checking bench for gate_tester: the gate under test is modelled as a
// 4-entry truth table, and expected results come from a function-level reference.
module tb_gate_tester;

    localparam int S   = 4;
    localparam int RUN = 4 * (S + 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       c_in;
    logic       a_out, b_out, busy, done, pass, err_sel;
    logic [3:0] fail_vec;
    logic [2:0] state_dbg;
    logic [3:0] dut_tab = 4'd0;

    int checks = 0;
    int failures = 0;

    gate_tester #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .c_in(c_in),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
        .fail_vec(fail_vec), .err_sel(err_sel), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign c_in = dut_tab[{a_out, b_out}];

    // Truth table of the selected function; bit i is the output for {A,B} = i.
    function automatic logic [3:0] ref_table(input int s);
        logic [3:0] t;
        t = 4'd0;
        for (int i = 0; i < 4; i++) begin
            int a, b, v;
            a = i / 2;
            b = i % 2;
            case (s)
                0:       v = a * b;
                1:       v = (a + b > 0) ? 1 : 0;
                2:       v = 1 - a * b;
                3:       v = (a + b == 0) ? 1 : 0;
                4:       v = (a + b) % 2;
                default: v = 1 - (a + b) % 2;
            endcase
            t[i] = v[0];
        end
        return t;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_and_check(input int s, input logic [3:0] tab, input bit scramble, input string name);
        logic [3:0] exp_fail;
        logic [1:0] exp_vec;
        int         done_edge;
        int         seq_err;
        sel      = 3'(s);
        dut_tab  = tab;
        exp_fail = tab ^ ref_table(s);
        done_edge = -1;
        seq_err   = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (scramble) sel = 3'($urandom_range(0, 7));
        for (int e = 0; e < RUN + 6; e++) begin
            exp_vec = (e < RUN) ? 2'(e / (S + 2)) : 2'd3;
            if (done === 1'b1) begin
                if (done_edge < 0) done_edge = e;
                else seq_err++;
            end
            if (busy !== (e < RUN) || {a_out, b_out} !== exp_vec) seq_err++;
            @(negedge clk);
        end
        checks++;
        if (done_edge !== RUN) begin
            failures++;
            $display("FAIL %s done_edge: got %0d want %0d", name, done_edge, RUN);
        end
        checks++;
        if (seq_err !== 0) begin
            failures++;
            $display("FAIL %s vector_sequence: got %0d bad cycles want 0", name, seq_err);
        end
        checks++;
        if (fail_vec !== exp_fail) begin
            failures++;
            $display("FAIL %s fail_vec: got %b want %b", name, fail_vec, exp_fail);
        end
        checks++;
        if (pass !== (exp_fail == 4'd0)) begin
            failures++;
            $display("FAIL %s pass: got %b want %b", name, pass, (exp_fail == 4'd0));
        end
        checks++;
        if (err_sel !== 1'b0) begin
            failures++;
            $display("FAIL %s err_sel: got %b want 0", name, err_sel);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_out, b_out, busy, done, pass, fail_vec, err_sel, state_dbg} !== 13'd0) begin
            failures++;
            $display("FAIL reset_state: got %b want 0",
                     {a_out, b_out, busy, done, pass, fail_vec, err_sel, state_dbg});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_functions();
        run_and_check(1, ref_table(1), 1'b0, "or_clean");
        run_and_check(1, 4'b0000, 1'b0, "or_stuck0");
        run_and_check(0, ref_table(1), 1'b0, "and_vs_or");
    endtask

    task automatic test_reserved();
        apply_reset();
        sel = 3'd6;
        dut_tab = 4'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL reserved_done: got %b want 1", done);
        end
        checks++;
        if ({err_sel, pass, fail_vec, busy, a_out, b_out} !== 9'b1_0_0000_0_00) begin
            failures++;
            $display("FAIL reserved_status: got %b want 100000000", {err_sel, pass, fail_vec, busy, a_out, b_out});
        end
        @(negedge clk);
        checks++;
        if ({done, busy, err_sel} !== 3'b001) begin
            failures++;
            $display("FAIL reserved_after: got %b want 001", {done, busy, err_sel});
        end
    endtask

    task automatic test_reset_midrun();
        int done_seen;
        done_seen = 0;
        sel = 3'd4;
        dut_tab = ref_table(4);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2 * (S + 2) + 2) @(negedge clk);
        checks++;
        if ({busy, a_out, b_out} !== 3'b110) begin
            failures++;
            $display("FAIL midrun_vector: got %b want 110", {busy, a_out, b_out});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_out, b_out, busy, done, pass, fail_vec, err_sel} !== 10'd0) begin
            failures++;
            $display("FAIL midrun_async_clear: got %b want 0", {a_out, b_out, busy, done, pass, fail_vec, err_sel});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        rst_n = 1'b1;
        checks++;
        if (done_seen !== 0) begin
            failures++;
            $display("FAIL midrun_no_done: got %0d pulses want 0", done_seen);
        end
        run_and_check(4, ref_table(4), 1'b0, "xor_after_reset");
    endtask

    task automatic test_back_to_back();
        int done_q[$];
        int bad_pass;
        bad_pass = 0;
        sel = 3'd2;
        dut_tab = ref_table(2);
        @(negedge clk);
        start = 1'b1;
        for (int e = 0; e < 90; e++) begin
            @(negedge clk);
            if (e == 59) start = 1'b0;
            if (done === 1'b1) begin
                done_q.push_back(e);
                if (pass !== 1'b1) bad_pass++;
            end
        end
        checks++;
        if (done_q.size() !== 3) begin
            failures++;
            $display("FAIL b2b_run_count: got %0d want 3", done_q.size());
        end
        checks++;
        if (done_q.size() > 0 && done_q[0] !== RUN) begin
            failures++;
            $display("FAIL b2b_first_done: got %0d want %0d", done_q[0], RUN);
        end
        for (int i = 1; i < done_q.size(); i++) begin
            checks++;
            if (done_q[i] - done_q[i-1] !== RUN + 2) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d want %0d", done_q[i] - done_q[i-1], RUN + 2);
            end
        end
        checks++;
        if (bad_pass !== 0) begin
            failures++;
            $display("FAIL b2b_pass: got %0d failing runs want 0", bad_pass);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            run_and_check(int'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), 1'b1, "random_run");
        end
    endtask

    initial begin
        test_reset();
        test_functions();
        test_reserved();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
